dram_request_issuer: RTL and testbench
======================================

// Module: dram_request_issuer
// PURPOSE
//  Requester-side end of the scheduler buffer interface. Queues load/store requests from a
//  cache/core client and drives dREN/dWEN/memaddr/memstore toward the DRAM scheduler buffer,
//  holding each request until request_done. Tracks outstanding reads and matches returning
//  memaddr_callback/data_callback to deliver read responses back to the client.
// PARAMETERS
//  WORD_W   32  address/data width; matches the scheduler buffer interface
//  DEPTH    4   request FIFO entries (power of 2, >=2)
//  OUTST    4   outstanding-read tracker entries (>=1)
// PORTS
//  CLK               in   1       clock, all state on rising edge
//  nRST              in   1       asynchronous active-low reset
//  req_valid         in   1       client request present
//  req_ready         out  1       FIFO can accept (= !fifo_full)
//  req_wen           in   1       1 = store, 0 = load
//  req_addr          in   WORD_W  request address
//  req_wdata         in   WORD_W  store data (ignored for loads)
//  dREN              out  1       read request to scheduler buffer
//  dWEN              out  1       write request to scheduler buffer
//  memaddr           out  WORD_W  request address to scheduler buffer
//  memstore          out  WORD_W  store data to scheduler buffer
//  request_done      in   1       scheduler accepted current request
//  callback_valid    in   1       data_callback/memaddr_callback valid this cycle
//  memaddr_callback  in   WORD_W  address of returning read
//  data_callback     in   WORD_W  returning read data
//  rsp_valid         out  1       one-cycle read response pulse
//  rsp_addr          out  WORD_W  response address
//  rsp_data          out  WORD_W  response data
//  wr_done           out  1       one-cycle store-accepted pulse
//  err_unmatched     out  1       one-cycle pulse: callback matched no tracker entry
//  busy              out  1       FIFO non-empty, FSM not IDLE, or any tracker entry valid
// BEHAVIOUR
//  Reset: every output 0; FIFO empty; tracker all invalid; FSM IDLE. Reset mid-transaction
//   drops dREN/dWEN immediately (async), discards queued and outstanding requests.
//  Enqueue: push {wen,addr,wdata} when req_valid && req_ready. Push+pop same cycle legal at
//   any occupancy incl. full (req_ready stays as computed from pre-pop count).
//  FSM (issuer_state_t):
//   IDLE  -> ISSUE when FIFO non-empty and (head is store or tracker has a free slot).
//           Read head with tracker full stalls in IDLE (no head-of-line bypass).
//   ISSUE -> drive dREN=~wen / dWEN=wen, memaddr/memstore from head, registered and held
//           stable until request_done. On request_done: pop head; load -> allocate lowest
//           free tracker slot {valid,addr}; store -> wr_done=1 next cycle; go IDLE.
//   Outputs deasserted in IDLE: at most one request per 2 cycles (required bubble).
//  request_done while IDLE is ignored.
//  Callback: on callback_valid, compare memaddr_callback to all valid tracker entries; the
//   lowest-index match is freed and next cycle rsp_valid=1, rsp_addr/rsp_data = registered
//   callback values. No match -> err_unmatched=1 next cycle, tracker unchanged.
//  Allocate and free in the same cycle: both take effect; free of slot k and allocate of
//   slot k same cycle impossible (allocate sees pre-free state). Free slot availability
//   for IDLE->ISSUE uses pre-update state.
//  Duplicate outstanding read addresses allowed; responses retire oldest-slot-first by index.
//  No response back-pressure: client must sink rsp_valid every cycle.
//  Widths: FIFO pointers clog2(DEPTH)+1 bits, wrap naturally; tracker count never > OUTST.
// STRUCTURE
//  dram_pack additions: issuer_state_t (IDLE, ISSUE), issue_req_t {wen, addr, wdata},
//   rd_track_t {valid, addr}; all parameterised by WORD_W from dram_pack.
//  Sub-module issuer_fifo (sync FIFO of issue_req_t, DEPTH, full/empty); tracker and FSM
//   live in dram_request_issuer.
// TESTING
//  1 Load 0x100: request_done 3 cycles after dREN; callback 0x100/0xDEADBEEF -> dREN held
//    stable 3 cycles, drops after done; rsp_valid 1 cycle later with 0x100/0xDEADBEEF.
//  2 Store 0x200/0x1234 -> dWEN=1, memstore=0x1234 until request_done; wr_done pulse next;
//    no tracker entry allocated, busy drops after.
//  3 Five back-to-back requests with DEPTH=4, no request_done -> req_ready=0 after 4th;
//    5th accepted on cycle after first pop; order preserved at memaddr.
//  4 OUTST=4 loads 0x0,0x4,0x8,0xC outstanding, fifth load 0x10 queued -> stays IDLE,
//    dREN=0; callback 0x8 -> rsp 0x8, then 0x10 issues next cycle.
//  5 Callback 0x999 with no match -> err_unmatched pulse, no rsp_valid; two loads to 0x40
//    then callback 0x40 -> slot 0 freed first, slot 1 still valid.
//  6 nRST low mid-ISSUE with 2 queued and 1 outstanding -> dREN/dWEN 0 same cycle, busy=0,
//    late callback after reset -> err_unmatched.

Source files
------------

// File: rtl/dram_request_issuer_pkg.sv
// Shared types for the requester side of the DRAM scheduler buffer interface.
package dram_pack;

  // Address/data width of the scheduler buffer interface.
  localparam int WORD_W = 32;

  // Issuer FSM: IDLE is the mandatory bubble between requests, ISSUE holds one request.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issuer_state_t;

  // One queued client request.
  typedef struct packed {
    logic              wen;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } issue_req_t;

  // One outstanding-read tracker entry.
  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] addr;
  } rd_track_t;

endpackage

// File: rtl/dram_request_issuer_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module issuer_fifo
  import dram_pack::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       i_push,
  input  issue_req_t i_data,
  input  logic       i_pop,
  output issue_req_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  issue_req_t  r_mem [DEPTH];
  logic        w_push_ok;
  logic        w_pop_ok;

  // Full/empty come from the pre-update pointers, so a push is refused while full
  // even if the head is popped in the same cycle.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; both pointers wrap naturally through the extra bit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents are don't-care until the write pointer passes them.
  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/dram_request_issuer.sv
// Queues client loads/stores, issues them one at a time to the scheduler buffer and
// matches returning read callbacks against a small outstanding-read tracker.
module dram_request_issuer
  import dram_pack::*;
#(
  parameter int DEPTH = 4,
  parameter int OUTST = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] memaddr,
  output logic [WORD_W-1:0] memstore,
  input  logic              request_done,
  input  logic              callback_valid,
  input  logic [WORD_W-1:0] memaddr_callback,
  input  logic [WORD_W-1:0] data_callback,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_addr,
  output logic [WORD_W-1:0] rsp_data,
  output logic              wr_done,
  output logic              err_unmatched,
  output logic              busy
);

  localparam int TW = (OUTST > 1) ? $clog2(OUTST) : 1;

  issuer_state_t     r_state;
  issuer_state_t     w_state_nx;
  logic              r_dren, r_dwen, w_dren_nx, w_dwen_nx;
  logic [WORD_W-1:0] r_memaddr, r_memstore, w_memaddr_nx, w_memstore_nx;
  logic              r_wr_done, w_wr_done_nx;
  logic              r_rsp_valid, r_err;
  logic [WORD_W-1:0] r_rsp_addr, r_rsp_data;
  rd_track_t         r_trk [OUTST];

  issue_req_t        w_push_data;
  issue_req_t        w_head;
  logic              w_full, w_empty, w_pop, w_alloc;
  logic              w_free_any, w_match_any, w_any_valid;
  logic [TW-1:0]     w_free_idx, w_match_idx;

  assign w_push_data = '{wen: req_wen, addr: req_addr, wdata: req_wdata};

  issuer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_push  (req_valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Tracker scan: lowest free slot, lowest-index callback match, any entry valid.
  always_comb begin
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    w_match_any = 1'b0;
    w_match_idx = '0;
    w_any_valid = 1'b0;
    for (int i = OUTST - 1; i >= 0; i--) begin
      if (r_trk[i].valid) begin
        w_any_valid = 1'b1;
        if (r_trk[i].addr == memaddr_callback) begin
          w_match_any = 1'b1;
          w_match_idx = TW'(i);
        end
      end else begin
        w_free_any = 1'b1;
        w_free_idx = TW'(i);
      end
    end
  end

  // Next-state and next-output logic; request outputs drop in IDLE to force the bubble.
  always_comb begin
    w_state_nx    = r_state;
    w_dren_nx     = 1'b0;
    w_dwen_nx     = 1'b0;
    w_memaddr_nx  = r_memaddr;
    w_memstore_nx = r_memstore;
    w_wr_done_nx  = 1'b0;
    w_pop         = 1'b0;
    w_alloc       = 1'b0;
    case (r_state)
      IDLE: begin
        // A load at the head waits for a tracker slot; nothing may overtake it.
        if (!w_empty && (w_head.wen || w_free_any)) begin
          w_state_nx    = ISSUE;
          w_dren_nx     = ~w_head.wen;
          w_dwen_nx     = w_head.wen;
          w_memaddr_nx  = w_head.addr;
          w_memstore_nx = w_head.wdata;
        end else begin
          w_state_nx = IDLE;
        end
      end
      ISSUE: begin
        if (request_done) begin
          w_state_nx   = IDLE;
          w_pop        = 1'b1;
          w_alloc      = ~w_head.wen;
          w_wr_done_nx = w_head.wen;
        end else begin
          w_dren_nx = r_dren;
          w_dwen_nx = r_dwen;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // FSM state and registered scheduler-side outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_dren     <= 1'b0;
      r_dwen     <= 1'b0;
      r_memaddr  <= '0;
      r_memstore <= '0;
      r_wr_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_dren     <= w_dren_nx;
      r_dwen     <= w_dwen_nx;
      r_memaddr  <= w_memaddr_nx;
      r_memstore <= w_memstore_nx;
      r_wr_done  <= w_wr_done_nx;
    end
  end

  // Tracker update: free and allocate never collide because allocation picks an invalid slot.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < OUTST; i++) begin
        r_trk[i] <= '0;
      end
    end else begin
      if (callback_valid && w_match_any) begin
        r_trk[w_match_idx].valid <= 1'b0;
      end
      if (w_alloc) begin
        r_trk[w_free_idx].valid <= 1'b1;
        r_trk[w_free_idx].addr  <= r_memaddr;
      end
    end
  end

  // Registered read response and unmatched-callback pulses.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= callback_valid && w_match_any;
      r_err       <= callback_valid && !w_match_any;
      if (callback_valid) begin
        r_rsp_addr <= memaddr_callback;
        r_rsp_data <= data_callback;
      end
    end
  end

  assign req_ready     = !w_full;
  assign dREN          = r_dren;
  assign dWEN          = r_dwen;
  assign memaddr       = r_memaddr;
  assign memstore      = r_memstore;
  assign wr_done       = r_wr_done;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_addr      = r_rsp_addr;
  assign rsp_data      = r_rsp_data;
  assign err_unmatched = r_err;
  assign busy          = !w_empty || (r_state != IDLE) || w_any_valid;

endmodule

// File: tb/tb_dram_request_issuer.sv
// Bench for dram_request_issuer: directed scenarios followed by random traffic, all
// checked against a transaction-level model (request queue + outstanding-read slots).
module tb_dram_request_issuer;
  import dram_pack::*;

  localparam int DEPTH = 4;
  localparam int OUTST = 4;
  localparam int W     = WORD_W;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         req_valid, req_wen, request_done, callback_valid;
  logic [W-1:0] req_addr, req_wdata, memaddr_callback, data_callback;
  logic         req_ready, dREN, dWEN, rsp_valid, wr_done, err_unmatched, busy;
  logic [W-1:0] memaddr, memstore, rsp_addr, rsp_data;

  always #5 CLK = ~CLK;

  dram_request_issuer #(.DEPTH(DEPTH), .OUTST(OUTST)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .dREN(dREN), .dWEN(dWEN), .memaddr(memaddr), .memstore(memstore),
    .request_done(request_done), .callback_valid(callback_valid),
    .memaddr_callback(memaddr_callback), .data_callback(data_callback),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .wr_done(wr_done), .err_unmatched(err_unmatched), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state.
  issue_req_t   exp_q[$];
  logic         slot_v [OUTST];
  logic [W-1:0] slot_a [OUTST];
  logic         in_flight;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_out();
    int c = 0;
    for (int i = 0; i < OUTST; i++) if (slot_v[i]) c++;
    return c;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < OUTST; i++) begin
      slot_v[i] = 1'b0;
      slot_a[i] = '0;
    end
    in_flight = 1'b0;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    request_done = 1'b0; callback_valid = 1'b0;
    memaddr_callback = '0; data_callback = '0;
  endtask

  // Called at a falling edge with inputs already driven: predict the effect of the
  // coming rising edge, advance one cycle, and compare at the next falling edge.
  task automatic tick();
    logic         issuing, exp_rsp, exp_err, exp_wr, exp_quiet;
    logic [W-1:0] exp_ra, exp_rd;
    int           m;
    issue_req_t   nr;
    issuing = dREN || dWEN;
    exp_rsp = 1'b0; exp_err = 1'b0; exp_wr = 1'b0; exp_quiet = 1'b0;
    exp_ra = '0; exp_rd = '0; m = -1;
    chk("req_ready", req_ready, exp_q.size() < DEPTH);
    if (issuing && !in_flight) begin
      chk("issue_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        chk("issue_dwen", dWEN, exp_q[0].wen);
        chk("issue_dren", dREN, !exp_q[0].wen);
        chk("issue_addr", memaddr, exp_q[0].addr);
        if (exp_q[0].wen) chk("issue_wdata", memstore, exp_q[0].wdata);
        else chk("issue_slot_free", n_out() < OUTST, 1'b1);
      end
      in_flight = 1'b1;
    end else if (issuing && exp_q.size() != 0) begin
      chk("hold_addr", memaddr, exp_q[0].addr);
    end
    if (callback_valid) begin
      for (int i = 0; i < OUTST; i++)
        if (m < 0 && slot_v[i] && slot_a[i] == memaddr_callback) m = i;
      if (m >= 0) begin
        exp_rsp = 1'b1; exp_ra = memaddr_callback; exp_rd = data_callback;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (in_flight && request_done) begin
      if (exp_q.size() != 0) begin
        if (exp_q[0].wen) exp_wr = 1'b1;
        else begin
          for (int i = 0; i < OUTST; i++)
            if (!slot_v[i] && exp_q[0].addr !== 'x) begin
              slot_v[i] = 1'b1; slot_a[i] = exp_q[0].addr; break;
            end
        end
        void'(exp_q.pop_front());
      end
      in_flight = 1'b0;
      exp_quiet = 1'b1;
    end
    if (m >= 0) slot_v[m] = 1'b0;
    if (req_valid && req_ready) begin
      nr.wen = req_wen; nr.addr = req_addr; nr.wdata = req_wdata;
      exp_q.push_back(nr);
    end
    @(posedge CLK);
    @(negedge CLK);
    chk("rsp_valid", rsp_valid, exp_rsp);
    if (exp_rsp) begin
      chk("rsp_addr", rsp_addr, exp_ra);
      chk("rsp_data", rsp_data, exp_rd);
    end
    chk("err_unmatched", err_unmatched, exp_err);
    chk("wr_done", wr_done, exp_wr);
    if (exp_quiet) chk("bubble", dREN | dWEN, 1'b0);
    chk("busy", busy, (exp_q.size() != 0) || (n_out() != 0) || dREN || dWEN);
  endtask

  task automatic push_req(input logic wen, input logic [W-1:0] a, input logic [W-1:0] d);
    logic ok = 1'b0;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = req_ready;
      tick();
    end
    chk("push_accepted", ok, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic wait_issue();
    for (int k = 0; k < 10 && !(dREN || dWEN); k++) tick();
    chk("issue_seen", dREN | dWEN, 1'b1);
  endtask

  task automatic complete(input int hold);
    repeat (hold) tick();
    request_done = 1'b1;
    tick();
    request_done = 1'b0;
  endtask

  task automatic callback(input logic [W-1:0] a, input logic [W-1:0] d);
    callback_valid = 1'b1; memaddr_callback = a; data_callback = d;
    tick();
    callback_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    #1;
    chk("rst_dren", dREN, 1'b0);
    chk("rst_dwen", dWEN, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp", rsp_valid, 1'b0);
    chk("rst_wr_done", wr_done, 1'b0);
    chk("rst_err", err_unmatched, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    clear_model();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    int k;
    idle_inputs();
    clear_model();
    nRST = 1'b0;
    @(negedge CLK);
    do_reset();

    // Load 0x100, held three cycles before request_done, then its callback.
    push_req(1'b0, 32'h0000_0100, 32'h0);
    wait_issue();
    chk("t1_dren", dREN, 1'b1);
    complete(3);
    callback(32'h0000_0100, 32'hDEAD_BEEF);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_addr", rsp_addr, 32'h0000_0100);
    chk("t1_rsp_data", rsp_data, 32'hDEAD_BEEF);

    // Store 0x200/0x1234.
    push_req(1'b1, 32'h0000_0200, 32'h0000_1234);
    wait_issue();
    chk("t2_dwen", dWEN, 1'b1);
    chk("t2_memstore", memstore, 32'h0000_1234);
    complete(2);
    chk("t2_wr_done", wr_done, 1'b1);
    tick();
    chk("t2_busy_low", busy, 1'b0);

    // Fill the FIFO with four stores, then a fifth waits for the first pop.
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_wen = 1'b1;
      req_addr = 32'h0000_0300 + 32'(i * 4); req_wdata = 32'h0000_5000 + 32'(i);
      tick();
    end
    chk("t3_full", req_ready, 1'b0);
    req_addr = 32'h0000_0310; req_wdata = 32'h0000_5004;
    request_done = 1'b1;
    tick();
    request_done = 1'b0;
    chk("t3_ready_after_pop", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_issue();
      complete(0);
    end
    tick();

    // Four loads fill the tracker; a fifth load stalls until a slot is freed.
    for (int i = 0; i < 4; i++) begin
      push_req(1'b0, 32'(i * 4), 32'h0);
      wait_issue();
      complete(1);
    end
    push_req(1'b0, 32'h0000_0010, 32'h0);
    repeat (4) tick();
    chk("t4_stalled", dREN, 1'b0);
    callback(32'h0000_0008, 32'h0000_0888);
    chk("t4_rsp", rsp_valid, 1'b1);
    chk("t4_still_idle", dREN, 1'b0);
    tick();
    chk("t4_issue_dren", dREN, 1'b1);
    chk("t4_issue_addr", memaddr, 32'h0000_0010);
    complete(0);
    callback(32'h0000_0000, 32'h1);
    callback(32'h0000_0004, 32'h2);
    callback(32'h0000_000C, 32'h3);
    callback(32'h0000_0010, 32'h4);

    // Unmatched callback, then duplicate outstanding addresses.
    callback(32'h0000_0999, 32'h0);
    chk("t5_err", err_unmatched, 1'b1);
    for (int i = 0; i < 2; i++) begin
      push_req(1'b0, 32'h0000_0040, 32'h0);
      wait_issue();
      complete(0);
    end
    callback(32'h0000_0040, 32'hAAAA_0001);
    chk("t5_one_left", busy, 1'b1);
    callback(32'h0000_0040, 32'hAAAA_0002);
    chk("t5_second_rsp", rsp_valid, 1'b1);
    chk("t5_drained", busy, 1'b0);

    // Reset mid-issue with two queued and one outstanding.
    push_req(1'b0, 32'h0000_0300, 32'h0);
    wait_issue();
    complete(0);
    push_req(1'b1, 32'h0000_0500, 32'h11);
    push_req(1'b1, 32'h0000_0504, 32'h22);
    wait_issue();
    do_reset();
    callback(32'h0000_0300, 32'h33);
    chk("t6_late_cb_err", err_unmatched, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_wen   = 1'($urandom_range(0, 1));
      req_addr  = 32'h0000_1000 + 32'($urandom_range(0, 7) * 4);
      req_wdata = $urandom;
      request_done   = ($urandom_range(0, 3) == 0);
      callback_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        callback_valid = 1'b1;
        data_callback  = $urandom;
        memaddr_callback = 32'hBAD0_0000 + 32'($urandom_range(0, 255));
        if (n_out() > 0 && $urandom_range(0, 4) != 0) begin
          k = $urandom_range(0, OUTST - 1);
          for (int i = 0; i < OUTST; i++)
            if (slot_v[(k + i) % OUTST]) begin
              memaddr_callback = slot_a[(k + i) % OUTST];
              break;
            end
        end
      end
      tick();
    end

    // Drain: complete everything still queued and return every outstanding read.
    req_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!busy && exp_q.size() == 0 && n_out() == 0) break;
      request_done = 1'b1;
      callback_valid = 1'b0;
      for (int i = 0; i < OUTST; i++)
        if (slot_v[i]) begin
          callback_valid = 1'b1; memaddr_callback = slot_a[i]; data_callback = $urandom;
          break;
        end
      tick();
    end
    idle_inputs();
    tick();
    chk("drain_busy", busy, 1'b0);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_outst", n_out(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
